// File: rtl/bishift_pkg.sv
// Shared types and helpers for the data-reversal bidirectional shifter pipeline.
// A stage_t bundles one in-flight request: valid, partially shifted data and its control flags.
package bishift_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_SELW  = 3;

  typedef struct packed {
    logic                 valid;
    logic [DEF_WIDTH-1:0] data;
    logic                 left;
    logic                 rot;
    logic [DEF_SELW-1:0]  sel;
  } stage_t;

  function automatic logic [DEF_WIDTH-1:0] bitrev(input logic [DEF_WIDTH-1:0] x);
    logic [DEF_WIDTH-1:0] r;
    for (int i = 0; i < DEF_WIDTH; i++) r[i] = x[DEF_WIDTH-1-i];
    return r;
  endfunction

endpackage

// File: rtl/bishift_stage.sv
// One log-shifter level: right-shift or rotate by SHAMT when its sel bit is set, then register.
// It owns its valid bit and loads whenever it is empty or its contents leave this cycle.
module bishift_stage
  import bishift_pkg::*;
#(
  parameter int SHAMT = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  stage_t up,
  input  logic   dn_ready,
  output logic   up_ready,
  output stage_t q
);

  localparam int W = DEF_WIDTH;
  localparam int K = $clog2(SHAMT);

  logic   adv;
  stage_t nxt;

  always_comb begin
    adv      = q.valid & dn_ready;
    up_ready = !q.valid | adv;
    nxt      = up;
    if (up.sel[K]) begin
      if (up.rot) nxt.data = (up.data >> SHAMT) | (up.data << (W - SHAMT));
      else        nxt.data = up.data >> SHAMT;
    end
  end

  // Data only changes on a real load, so a drained stage keeps its last contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (up_ready && up.valid) begin
      q <= nxt;
    end else if (adv) begin
      q.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/bishift_datarev_pipe.sv
// Pipelined bidirectional shifter: left shifts are done as reverse / right-shift / reverse.
// One log level per register stage, valid/ready on both sides, ready ripples back combinationally.
module bishift_datarev_pipe
  import bishift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SELW  = DEF_SELW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_left,
  input  logic             in_rot,
  input  logic [SELW-1:0]  in_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_left
);

  // The stage record is sized by the package, so the instance must match it.
  if (WIDTH != DEF_WIDTH || SELW != DEF_SELW || WIDTH != (1 << SELW)) begin : g_bad_param
    $error("bishift_datarev_pipe: WIDTH/SELW must match bishift_pkg defaults");
  end

  stage_t entry;
  stage_t last;

  always_comb begin
    entry.valid = in_valid;
    entry.data  = in_left ? bitrev(in_data) : in_data;
    entry.left  = in_left;
    entry.rot   = in_rot;
    entry.sel   = in_sel;
  end

  for (genvar k = 0; k < SELW; k++) begin : g_st
    stage_t up_s;
    stage_t q;
    logic   up_rdy;
    logic   dn_rdy;

    if (k == 0) begin : g_first
      assign up_s = entry;
    end else begin : g_mid
      assign up_s = g_st[k-1].q;
    end

    if (k == SELW - 1) begin : g_tail
      assign dn_rdy = out_ready;
    end else begin : g_link
      assign dn_rdy = g_st[k+1].up_rdy;
    end

    bishift_stage #(.SHAMT(1 << k)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .up       (up_s),
      .dn_ready (dn_rdy),
      .up_ready (up_rdy),
      .q        (q)
    );
  end

  assign last      = g_st[SELW-1].q;
  assign in_ready  = g_st[0].up_rdy;
  assign out_valid = last.valid;
  assign out_left  = last.left;
  assign out_data  = last.left ? bitrev(last.data) : last.data;

endmodule
